// File: rtl/line_buffer_3row_pkg.sv
// Shared defaults for the 3-row line buffer and the downstream median stage.
// Holds the pixel width, picture geometry, 9-bit counter width, and the
// row classification used to decide when the column triple is usable.
package line_buffer_3row_pkg;

  localparam int unsigned LB_WIDTH      = 24;
  localparam int unsigned LB_PIC_WIDTH  = 320;
  localparam int unsigned LB_PIC_HEIGHT = 240;
  localparam int unsigned LB_CNT_W      = 9;

  typedef enum logic [1:0] {
    ROW_FIRST  = 2'd0,
    ROW_SECOND = 2'd1,
    ROW_BODY   = 2'd2
  } row_class_e;

  function automatic row_class_e row_class(input logic [LB_CNT_W-1:0] row);
    row_class_e cls;
    if (row == '0) begin
      cls = ROW_FIRST;
    end else if (row == LB_CNT_W'(1)) begin
      cls = ROW_SECOND;
    end else begin
      cls = ROW_BODY;
    end
    return cls;
  endfunction

endpackage

// File: rtl/line_buffer_3row_line_ram.sv
// line_ram: simple dual-port line memory, synchronous read-before-write.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   rd_en, rd_addr      read strobe and address; rd_data registered
//   wr_en, wr_addr,     write strobe, address and data
//   wr_data
// The array itself is never reset; only the read data register is.
module line_ram
  import line_buffer_3row_pkg::*;
#(
  parameter int unsigned WIDTH = LB_WIDTH,
  parameter int unsigned DEPTH = LB_PIC_WIDTH,
  parameter int unsigned AW    = LB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Combinational fetch of the pre-write contents gives read-before-write
  // when read and write address coincide on the same edge.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer_3row.sv
// line_buffer_3row: turns a raster pixel stream into vertical column triples
// (row r-2, r-1, r) for a 3x3 median stage. Latency is one cycle.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   valid_in        pixel strobe
//   sof             start of frame, qualified by valid_in
//   din             raster-order pixel
//   dout1/2/3       rows r-2 / r-1 / r at the current column
//   valid_out       dout1..3 form a valid triple
// Build option: LINEBUF_BORDER_REPLICATE_EN -- emit every row, replicating
// the top border instead of dropping rows 0 and 1.
module line_buffer_3row
  import line_buffer_3row_pkg::*;
#(
  parameter int unsigned WIDTH      = LB_WIDTH,
  parameter int unsigned PIC_WIDTH  = LB_PIC_WIDTH,
  parameter int unsigned PIC_HEIGHT = LB_PIC_HEIGHT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             sof,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             valid_out
);

  localparam logic [LB_CNT_W-1:0] COL_LAST = LB_CNT_W'(PIC_WIDTH - 1);
  localparam logic [LB_CNT_W-1:0] ROW_LAST = LB_CNT_W'(PIC_HEIGHT - 1);

  logic [LB_CNT_W-1:0] col_d, col_q;
  logic [LB_CNT_W-1:0] row_d, row_q;
  logic [LB_CNT_W-1:0] eff_col, eff_row;
  logic [WIDTH-1:0]    dout3_d, dout3_q;
  logic                valid_d, valid_q;
  logic                b_wr_pend_d, b_wr_pend_q;
  logic [LB_CNT_W-1:0] b_wr_addr_d, b_wr_addr_q;
  logic [WIDTH-1:0]    a_rd, b_rd;

  // sof overrides the counters for the pixel it qualifies.
  always_comb begin
    eff_col     = sof ? '0 : col_q;
    eff_row     = sof ? '0 : row_q;
    col_d       = col_q;
    row_d       = row_q;
    dout3_d     = dout3_q;
    b_wr_pend_d = valid_in;
    b_wr_addr_d = b_wr_addr_q;
`ifdef LINEBUF_BORDER_REPLICATE_EN
    valid_d     = valid_in;
`else
    valid_d     = valid_in && (row_class(eff_row) == ROW_BODY);
`endif
    if (valid_in) begin
      dout3_d     = din;
      b_wr_addr_d = eff_col;
      if (eff_col == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row == ROW_LAST) ? '0 : eff_row + LB_CNT_W'(1);
      end else begin
        col_d = eff_col + LB_CNT_W'(1);
        row_d = eff_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      dout3_q     <= '0;
      valid_q     <= 1'b0;
      b_wr_pend_q <= 1'b0;
      b_wr_addr_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      dout3_q     <= dout3_d;
      valid_q     <= valid_d;
      b_wr_pend_q <= b_wr_pend_d;
      b_wr_addr_q <= b_wr_addr_d;
    end
  end

  // Line A: row r-1. Written with din at the address it is read from.
  line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH),
    .AW    (LB_CNT_W)
  ) u_line_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (valid_in),
    .rd_addr (eff_col),
    .rd_data (a_rd),
    .wr_en   (valid_in),
    .wr_addr (eff_col),
    .wr_data (din)
  );

  // Line B: row r-2. It receives A's old word, which only exists in A's read
  // register one cycle later, so the B write trails by a cycle. A colliding
  // B read needs the same column on consecutive accepted pixels, which only
  // happens for row 0 after sof/reset, where B data is never observed.
  line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH),
    .AW    (LB_CNT_W)
  ) u_line_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (valid_in),
    .rd_addr (eff_col),
    .rd_data (b_rd),
    .wr_en   (b_wr_pend_q),
    .wr_addr (b_wr_addr_q),
    .wr_data (a_rd)
  );

`ifdef LINEBUF_BORDER_REPLICATE_EN
  row_class_e row_cls_d, row_cls_q;

  always_comb begin
    row_cls_d = row_cls_q;
    if (valid_in) begin
      row_cls_d = row_class(eff_row);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cls_q <= ROW_FIRST;
    end else begin
      row_cls_q <= row_cls_d;
    end
  end

  // Top border: substitute the newest available row for rows not yet seen.
  always_comb begin
    dout1 = b_rd;
    dout2 = a_rd;
    case (row_cls_q)
      ROW_FIRST: begin
        dout1 = dout3_q;
        dout2 = dout3_q;
      end
      ROW_SECOND: begin
        dout1 = a_rd;
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    dout1 = b_rd;
    dout2 = a_rd;
  end
`endif

  assign dout3     = dout3_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
module tb_line_buffer_3row;

  localparam int W = 8;
  localparam int H = 6;
  localparam int BODY_PULSES = (H - 2) * W;  // 32 per full frame

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        sof;
  logic [23:0] din;
  logic [23:0] dout1, dout2, dout3;
  logic        valid_out;

  always #5 clk = ~clk;

  line_buffer_3row #(
    .WIDTH      (24),
    .PIC_WIDTH  (W),
    .PIC_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .sof       (sof),
    .din       (din),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .valid_out (valid_out)
  );

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [71:0] exp_q[$];
  logic [23:0] first_d1, first_d2, first_d3;

  // Reference position of the next pixel; data = {frame id, row, col}.
  int mrow = 0;
  int mcol = 0;
  int fid  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [23:0] px);
    @(negedge clk);
    valid_in = v;
    sof      = s;
    din      = px;
  endtask

  task automatic pixel(input logic s);
    logic [23:0] px;
    if (s) begin
      mrow = 0;
      mcol = 0;
      fid++;
    end
    px = {8'(fid), 8'(mrow), 8'(mcol)};
    if (mrow >= 2)
      exp_q.push_back({8'(fid), 8'(mrow - 2), 8'(mcol),
                       8'(fid), 8'(mrow - 1), 8'(mcol), px});
    drive(1'b1, s, px);
    mcol++;
    if (mcol == W) begin
      mcol = 0;
      mrow++;
      if (mrow == H) begin
        mrow = 0;
        fid++;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 24'hA5A5A5);
  endtask

  task automatic pulses_since(input string name, input int start, input int req);
    idle();
    idle();
    chk(name, 32'(pulses - start), 32'(req));
  endtask

  // Monitor: pops the scoreboard on every valid_out and checks hold behaviour
  // after a cycle with valid_in low.
  initial begin : monitor
    logic        vin_s;
    logic [23:0] l1, l2, l3;
    logic [71:0] e;
    l1 = '0; l2 = '0; l3 = '0;
    forever begin
      @(posedge clk);
      vin_s = valid_in;
      #1;
      if (rst_n) begin
        if (!vin_s) begin
          chk("valid_after_idle", 32'(valid_out), 32'd0);
          chk("hold_d1", 32'(dout1), 32'(l1));
          chk("hold_d2", 32'(dout2), 32'(l2));
          chk("hold_d3", 32'(dout3), 32'(l3));
        end
        if (valid_out) begin
          if (pulses == 0) begin
            first_d1 = dout1; first_d2 = dout2; first_d3 = dout3;
          end
          pulses++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual=%h_%h_%h required=no_pulse", dout1, dout2, dout3);
          end else begin
            e = exp_q.pop_front();
            chk("dout1", 32'(dout1), 32'(e[71:48]));
            chk("dout2", 32'(dout2), 32'(e[47:24]));
            chk("dout3", 32'(dout3), 32'(e[23:0]));
          end
        end
      end
      l1 = dout1; l2 = dout2; l3 = dout3;
    end
  end

  initial begin : stim
    int start;
    rst_n = 1'b0; valid_in = 1'b0; sof = 1'b0; din = '0;
    #2;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_d1", 32'(dout1), 32'd0);
    chk("rst_d2", 32'(dout2), 32'd0);
    chk("rst_d3", 32'(dout3), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Three continuous frames: no sof, sof back-to-back, natural wrap.
    start = pulses;
    for (int i = 0; i < W * H; i++) pixel(1'b0);
    for (int i = 0; i < W * H; i++) pixel(i == 0);
    for (int i = 0; i < W * H; i++) pixel(1'b0);
    pulses_since("cont_pulses", start, 3 * BODY_PULSES);
    chk("first_d1", 32'(first_d1), 32'h000000);
    chk("first_d2", 32'(first_d2), 32'h000100);
    chk("first_d3", 32'(first_d3), 32'h000200);

    // valid_in toggling 1,0,1,0.
    start = pulses;
    for (int i = 0; i < W * H; i++) begin
      pixel(i == 0);
      idle();
    end
    pulses_since("toggle_pulses", start, BODY_PULSES);

    // Mid-frame sof at row 3 col 5: 8 + 5 pulses before, full frame after.
    start = pulses;
    pixel(1'b1);
    while (!(mrow == 3 && mcol == 5)) pixel(1'b0);
    for (int i = 0; i < W * H; i++) pixel(i == 0);
    pulses_since("abort_pulses", start, W + 5 + BODY_PULSES);

    // Reset at row 2 col 3: 3 pulses before; next frame starts at row 0 w/o sof.
    start = pulses;
    pixel(1'b1);
    while (!(mrow == 2 && mcol == 3)) pixel(1'b0);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_out), 32'd0);
    chk("mid_rst_d1", 32'(dout1), 32'd0);
    chk("mid_rst_d2", 32'(dout2), 32'd0);
    chk("mid_rst_d3", 32'(dout3), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mrow = 0; mcol = 0; fid++;
    for (int i = 0; i < W * H; i++) pixel(1'b0);
    pulses_since("reset_pulses", start, 3 + BODY_PULSES);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
